hack_data_memory: RTL

- Data-memory stage directly downstream of the Hack CPU.
- Consumes the CPU's addressM/outM/writeM and returns inM.
- Maps RAM, screen buffer and keyboard register into the 15-bit Hack address space.
- Keyboard codes arrive through a small valid/ready FIFO. A registered second read port lets a video scanner fetch screen words.

---
 rtl/hack_mem_pkg.sv | 27 ++
 rtl/hack_key_fifo.sv | 54 +++++
 rtl/hack_data_memory.sv | 101 ++++++++++
 3 files changed

// File: rtl/hack_mem_pkg.sv
// Shared Hack memory-map constants, region encoding and the address decoder.
// Used by hack_data_memory and the CPU side of the design.
package hack_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam logic [ADDR_W-1:0] RAM_BASE = 15'h0000;
  localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_SCR  = 2'd1,
    REG_KBD  = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  // RAM owns the lower half, the screen the next 8K words, KBD is one word.
  function automatic region_t decodeRegion(input logic [ADDR_W-1:0] addr);
    if ((addr & 15'h4000) == RAM_BASE)      return REG_RAM;
    else if ((addr & 15'h6000) == SCR_BASE) return REG_SCR;
    else if (addr == KBD_ADDR)              return REG_KBD;
    else                                    return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_key_fifo.sv
// Synchronous keyboard FIFO with asynchronous active-high reset.
// Zero codes complete the handshake but are not stored ("no key").
module hack_key_fifo
  import hack_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pushData,
  input  logic         pushValid,
  output logic         pushReady,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  // Handshake: a code transfers on a rising clk where pushValid && pushReady;
  // pushReady depends only on registered state (never on pushValid).
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic          doWrite;
  logic          doRead;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pushReady = !full;
  assign doWrite   = pushValid && pushReady && (pushData != '0);
  assign doRead    = pop && !empty;
  assign head      = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PW'(1);
      if (doRead)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doWrite) - CW'(doRead);
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen buffer and keyboard FIFO behind the CPU's M port.
// Screen storage exists only when HACK_SCREEN_EN is defined.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KEY_DEPTH    = 4,
  localparam int KCW         = $clog2(KEY_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addressM,
  input  logic [DATA_W-1:0] outM,
  input  logic              writeM,
  output logic [DATA_W-1:0] inM,
  input  logic [DATA_W-1:0] key_code,
  input  logic              key_valid,
  output logic              key_ready,
  output logic [KCW-1:0]    key_count,
  input  logic [12:0]       scr_addr,
  output logic [DATA_W-1:0] scr_data,
  output logic              bad_addr
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  region_t           region;
  logic [DATA_W-1:0] ramRd;
  logic [DATA_W-1:0] scrRd;
  logic [DATA_W-1:0] keyHead;
  logic              keyEmpty;
  logic              keyFull;
  logic              kbdPop;

  assign region = decodeRegion(addressM);
  assign kbdPop = writeM && (region == REG_KBD);

  logic [DATA_W-1:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (writeM && region == REG_RAM) ram[addressM[RAM_AW-1:0]] <= outM;
  end
  assign ramRd = ram[addressM[RAM_AW-1:0]];

`ifdef HACK_SCREEN_EN
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  logic [DATA_W-1:0] screen [SCREEN_WORDS];

  always_ff @(posedge clk) begin
    if (writeM && region == REG_SCR) screen[addressM[SCR_AW-1:0]] <= outM;
  end
  assign scrRd = screen[addressM[SCR_AW-1:0]];

  // Video port reads before the same-edge CPU write lands, so it sees old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) scr_data <= '0;
    else       scr_data <= screen[scr_addr[SCR_AW-1:0]];
  end
`else
  logic unusedScrAddr;
  assign unusedScrAddr = ^scr_addr;
  assign scrRd         = '0;
  assign scr_data      = '0;
`endif

  hack_key_fifo #(
    .DEPTH (KEY_DEPTH),
    .W     (DATA_W)
  ) u_keyFifo (
    .clk       (clk),
    .reset     (reset),
    .pushData  (key_code),
    .pushValid (key_valid),
    .pushReady (key_ready),
    .pop       (kbdPop),
    .head      (keyHead),
    .count     (key_count),
    .full      (keyFull),
    .empty     (keyEmpty)
  );

  logic unusedFull;
  assign unusedFull = keyFull;

  always_comb begin
    inM = '0;
    case (region)
      REG_RAM:  inM = ramRd;
      REG_SCR:  inM = scrRd;
      REG_KBD:  inM = keyEmpty ? '0 : keyHead;
      default:  inM = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               bad_addr <= 1'b0;
    else if (writeM && region == REG_NONE)   bad_addr <= 1'b1;
  end

endmodule
